// File: rtl/uart_mux_pkg.sv
// Shared types and constants for the UART address/data packet transmitter.
// The address map matches the one the host tool already uses for its writes.
package uart_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BITS  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ADDR_LOADER_CONF = 8'h35;
  localparam logic [7:0] ADDR_ROM_DATA    = 8'h37;
  localparam logic [7:0] ADDR_BUTTONS_0   = 8'h40;
  localparam logic [7:0] ADDR_BUTTONS_1   = 8'h41;
  localparam logic [7:0] ADDR_STATUS_BASE = 8'h50;
  localparam logic [7:0] ADDR_STATUS_LAST = 8'h5F;

  // Bit period in clocks, rounded to nearest.
  function automatic int calc_div(input int freq, input int baudrate);
    return (freq + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser. A byte is taken when start && ready; ready is also
// high in the last STOP clock so a following byte can start with no idle gap.
//   state | meaning
//   IDLE  | line high, waiting for start
//   START | start bit (low) for DIV clocks
//   BITS  | 8 data bits, LSB first, DIV clocks each
//   STOP  | stop bit (high) for DIV clocks
module uart_tx_byte
  import uart_mux_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       active_nx,
  output logic       txd
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          txd_nx;
  logic          tick;
  logic          load;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
      txd   <= txd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    shift_nx = shift;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = START;
        end
      end
      START: if (tick) state_nx = BITS;
      BITS: begin
        if (tick) begin
          shift_nx = shift >> 1;
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (start) begin
            load     = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) shift_nx = data;
    if (state_nx == IDLE || load || tick) cnt_nx = '0;
    else                                  cnt_nx = cnt + CW'(1);
  end

  // Line level is computed for the next state so txd comes straight from a flop.
  always_comb begin
    ready     = (state == IDLE) || ((state == STOP) && tick);
    active_nx = (state_nx != IDLE);
    txd_nx    = 1'b1;
    case (state_nx)
      START:   txd_nx = 1'b0;
      BITS:    txd_nx = shift_nx[0];
      default: txd_nx = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_mux_tx.sv
// Packet transmitter: queues (addr, data) writes in a small FIFO and sends each
// as two back-to-back 8N1 bytes, address first, on uart_txd.
module uart_mux_tx
  import uart_mux_pkg::*;
#(
  parameter int FREQ     = 37_800_000,
  parameter int BAUDRATE = 921_600,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count,
  output logic                   uart_txd
);

  localparam int DIV = calc_div(FREQ, BAUDRATE);
  localparam int AW  = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [15:0]   head;
  logic [15:0]   pkt;
  logic          sel, pend, pend_nx;
  logic          push, pop;
  logic [AW:0]   count_nx;
  logic          tx_ready, tx_active_nx;
  logic [7:0]    tx_byte;

  assign head    = mem[rptr];
  assign push    = wr && !full;
  // A new packet is fetched only once the previous data byte has been handed over.
  assign pop     = !pend && tx_ready && (count != '0);
  assign tx_byte = sel ? pkt[15:8] : pkt[7:0];

  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + (AW+1)'(1);
    else if (pop && !push) count_nx = count - (AW+1)'(1);
    pend_nx = pend;
    if (pop)                          pend_nx = 1'b1;
    else if (pend && tx_ready && sel) pend_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      pend     <= 1'b0;
      sel      <= 1'b0;
      pkt      <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        pkt  <= {head[7:0], head[15:8]};
        sel  <= 1'b0;
      end else if (pend && tx_ready && !sel) begin
        sel  <= 1'b1;
      end
      if (wr && full) overflow <= 1'b1;
      count <= count_nx;
      full  <= (count_nx == (AW+1)'(DEPTH));
      busy  <= (count_nx != '0) || pend_nx || tx_active_nx;
      pend  <= pend_nx;
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_tx_byte (
    .clk       (clk),
    .reset     (reset),
    .start     (pend),
    .data      (tx_byte),
    .ready     (tx_ready),
    .active_nx (tx_active_nx),
    .txd       (uart_txd)
  );

endmodule
